// File: rtl/calc_enter_debounce_if.sv
// Signal bundle between the calculator input front-end and its environment.
// The master side drives the raw switches and button; the slave side is the front-end.
interface calc_enter_debounce_if #(
  parameter int NUM_WIDTH = 8,
  parameter int OP_WIDTH  = 2
);
  logic [NUM_WIDTH-1:0] NumRaw;
  logic [OP_WIDTH-1:0]  OpRaw;
  logic                 EnterRaw;
  logic [NUM_WIDTH-1:0] NumOut;
  logic [OP_WIDTH-1:0]  OpOut;
  logic                 EnterPulse;
  logic                 Busy;

  modport master (
    output NumRaw, OpRaw, EnterRaw,
    input  NumOut, OpOut, EnterPulse, Busy
  );

  modport slave (
    input  NumRaw, OpRaw, EnterRaw,
    output NumOut, OpOut, EnterPulse, Busy
  );
endinterface

// File: rtl/calc_enter_debounce.sv
// Calculator input front-end: synchronises the switches and Enter button, debounces
// Enter and emits one registered EnterPulse per clean press along with an operand/op snapshot.
module calc_enter_debounce #(
  parameter int NUM_WIDTH       = 8,
  parameter int OP_WIDTH        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 Reset,
  calc_enter_debounce_if.slave bus
);
  localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] enter_sync;
  logic [NUM_WIDTH-1:0]   num_sync [SYNC_STAGES];
  logic [OP_WIDTH-1:0]    op_sync  [SYNC_STAGES];

  logic                 enter_s;
  logic [NUM_WIDTH-1:0] num_s;
  logic [OP_WIDTH-1:0]  op_s;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 fire;
  logic                 pulse_q;
  logic [NUM_WIDTH-1:0] num_q;
  logic [OP_WIDTH-1:0]  op_q;

  // Every raw bit, including the operand bus, gets its own flop chain; the FSM and the
  // snapshot only ever look at the last stage.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      enter_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        num_sync[i] <= '0;
        op_sync[i]  <= '0;
      end
    end else begin
      enter_sync  <= {enter_sync[SYNC_STAGES-2:0], bus.EnterRaw};
      num_sync[0] <= bus.NumRaw;
      op_sync[0]  <= bus.OpRaw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        num_sync[i] <= num_sync[i-1];
        op_sync[i]  <= op_sync[i-1];
      end
    end
  end

  assign enter_s = enter_sync[SYNC_STAGES-1];
  assign num_s   = num_sync[SYNC_STAGES-1];
  assign op_s    = op_sync[SYNC_STAGES-1];

  // count holds how many consecutive samples have disagreed with the settled level;
  // it never goes past DEBOUNCE_CYCLES-1, so it cannot wrap.
  always_comb begin
    state_next = state;
    count_next = count;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (enter_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = HELD;
            count_next = '0;
            fire       = 1'b1;
          end else begin
            state_next = PRESS_WAIT;
            count_next = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!enter_s) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count == LAST) begin
          state_next = HELD;
          count_next = '0;
          fire       = 1'b1;
        end else begin
          count_next = count + ONE;
        end
      end
      HELD: begin
        if (!enter_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = IDLE;
            count_next = '0;
          end else begin
            state_next = RELEASE_WAIT;
            count_next = ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (enter_s) begin
          state_next = HELD;
          count_next = '0;
        end else if (count == LAST) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // The pulse is registered and self-clearing; the snapshot moves only on the pulse edge.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      count   <= '0;
      pulse_q <= 1'b0;
      num_q   <= '0;
      op_q    <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pulse_q <= fire;
      if (fire) begin
        num_q <= num_s;
        op_q  <= op_s;
      end
    end
  end

  assign bus.EnterPulse = pulse_q;
  assign bus.NumOut     = num_q;
  assign bus.OpOut      = op_q;
  assign bus.Busy       = (state != IDLE);
endmodule

// File: tb/tb_calc_enter_debounce.sv
// Bench for calc_enter_debounce: a default instance and a DEBOUNCE_CYCLES=1 instance,
// both compared every cycle against a run-length model of the debounced Enter level.
module tb_calc_enter_debounce;
  localparam int SYNC = 2;
  localparam int DBC  = 16;
  localparam int HIST = 64;

  logic clock = 1'b0;
  logic Reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  calc_enter_debounce_if #(.NUM_WIDTH(8), .OP_WIDTH(2)) bus0 ();
  calc_enter_debounce_if #(.NUM_WIDTH(8), .OP_WIDTH(2)) bus1 ();

  calc_enter_debounce #(
    .NUM_WIDTH(8), .OP_WIDTH(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DBC)
  ) dut0 (
    .clock(clock), .Reset(Reset), .bus(bus0)
  );

  calc_enter_debounce #(
    .NUM_WIDTH(8), .OP_WIDTH(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1)
  ) dut1 (
    .clock(clock), .Reset(Reset), .bus(bus1)
  );

  always #5 clock = ~clock;

  logic [11:0] obs0;
  logic [11:0] obs1;
  assign obs0 = {bus0.EnterPulse, bus0.Busy, bus0.NumOut, bus0.OpOut};
  assign obs1 = {bus1.EnterPulse, bus1.Busy, bus1.NumOut, bus1.OpOut};

  // Model: a settled level flips after D consecutive opposite samples of the input
  // as it was SYNC edges ago; a 0->1 flip is a press.
  logic [10:0] hist [2][HIST];
  int          edge_no [2] = '{0, 0};
  int          run     [2] = '{0, 0};
  logic        lvl     [2] = '{1'b0, 1'b0};
  logic        m_pulse [2] = '{1'b0, 1'b0};
  logic [7:0]  m_num   [2] = '{8'h00, 8'h00};
  logic [1:0]  m_op    [2] = '{2'b00, 2'b00};

  task automatic model_reset(input int k);
    edge_no[k] = 0;
    run[k]     = 0;
    lvl[k]     = 1'b0;
    m_pulse[k] = 1'b0;
    m_num[k]   = 8'h00;
    m_op[k]    = 2'b00;
  endtask

  task automatic model_edge(input int k, input int d, input logic [10:0] raw);
    logic [10:0] seen;
    edge_no[k] = edge_no[k] + 1;
    hist[k][edge_no[k] % HIST] = raw;
    seen = (edge_no[k] > SYNC) ? hist[k][(edge_no[k] - SYNC) % HIST] : 11'h000;
    m_pulse[k] = 1'b0;
    if (seen[10] != lvl[k]) begin
      run[k] = run[k] + 1;
      if (run[k] == d) begin
        lvl[k] = seen[10];
        run[k] = 0;
        if (lvl[k]) begin
          m_pulse[k] = 1'b1;
          m_num[k]   = seen[7:0];
          m_op[k]    = seen[9:8];
        end
      end
    end else begin
      run[k] = 0;
    end
  endtask

  function automatic logic [11:0] model_vec(input int k);
    return {m_pulse[k], (lvl[k] | (run[k] != 0)), m_num[k], m_op[k]};
  endfunction

  always @(posedge clock or posedge Reset) begin
    if (Reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, DBC, {bus0.EnterRaw, bus0.OpRaw, bus0.NumRaw});
      model_edge(1, 1,   {bus1.EnterRaw, bus1.OpRaw, bus1.NumRaw});
    end
  end

  task automatic do_reset();
    @(negedge clock);
    Reset = 1'b1;
    bus0.EnterRaw = 1'b0; bus0.NumRaw = 8'h00; bus0.OpRaw = 2'b00;
    bus1.EnterRaw = 1'b0; bus1.NumRaw = 8'h00; bus1.OpRaw = 2'b00;
    repeat (2) @(negedge clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if (obs0 !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_dut0: got %h expected %h", obs0, 12'h000);
    end
    n_checks++;
    if (obs1 !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_dut1: got %h expected %h", obs1, 12'h000);
    end
    do_reset();
  endtask

  task automatic test_press();
    int pulses = 0;
    do_reset();
    bus0.NumRaw = 8'h2A; bus0.OpRaw = 2'b01; bus0.EnterRaw = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      n_checks++;
      if (obs0 !== model_vec(0)) begin
        n_fail++;
        $display("[TB] FAIL press_model c=%0d: got %h expected %h", c, obs0, model_vec(0));
      end
      n_checks++;
      if (bus0.EnterPulse !== (c == SYNC + DBC)) begin
        n_fail++;
        $display("[TB] FAIL press_latency c=%0d: got %b expected %b", c, bus0.EnterPulse, (c == SYNC + DBC));
      end
      if (bus0.EnterPulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL press_count: got %0d expected 1", pulses);
    end
    n_checks++;
    if ({bus0.NumOut, bus0.OpOut} !== {8'h2A, 2'b01}) begin
      n_fail++;
      $display("[TB] FAIL press_snapshot: got %h/%b expected 2a/01", bus0.NumOut, bus0.OpOut);
    end
    bus0.EnterRaw = 1'b0;
    repeat (SYNC + DBC + 2) @(negedge clock);
    n_checks++;
    if (bus0.Busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL press_idle: got Busy=%b expected 0", bus0.Busy);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    do_reset();
    bus0.NumRaw = 8'($urandom); bus0.OpRaw = 2'($urandom);
    for (int c = 1; c <= 46; c++) begin
      bus0.EnterRaw = (c <= 10) || (c >= 14 && c <= 43);
      @(negedge clock);
      n_checks++;
      if (obs0 !== model_vec(0)) begin
        n_fail++;
        $display("[TB] FAIL glitch_model c=%0d: got %h expected %h", c, obs0, model_vec(0));
      end
      n_checks++;
      if (bus0.EnterPulse !== (c == 13 + SYNC + DBC)) begin
        n_fail++;
        $display("[TB] FAIL glitch_latency c=%0d: got %b expected %b", c, bus0.EnterPulse, (c == 13 + SYNC + DBC));
      end
      if (bus0.EnterPulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL glitch_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_release_bounce();
    int lens [6] = '{25, 3, 2, 4, 2, 24};
    int c = 0;
    int pulses = 0;
    int last_busy = 0;
    do_reset();
    bus0.NumRaw = 8'($urandom); bus0.OpRaw = 2'($urandom);
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < lens[seg]; i++) begin
        bus0.EnterRaw = (seg % 2 == 0);
        @(negedge clock);
        c++;
        n_checks++;
        if (obs0 !== model_vec(0)) begin
          n_fail++;
          $display("[TB] FAIL bounce_model c=%0d: got %h expected %h", c, obs0, model_vec(0));
        end
        if (bus0.EnterPulse === 1'b1) pulses++;
        if (bus0.Busy === 1'b1) last_busy = c;
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL bounce_count: got %0d expected 1", pulses);
    end
    // Final fall is raw at edge 37, seen at 39; the 16th low sample lands on edge 54.
    n_checks++;
    if (last_busy != 53) begin
      n_fail++;
      $display("[TB] FAIL bounce_busy_fall: got last busy cycle %0d expected 53", last_busy);
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] exp_num;
    do_reset();
    bus0.OpRaw = 2'b10;
    for (int c = 1; c <= 75; c++) begin
      bus0.EnterRaw = (c <= 30) || (c >= 51);
      bus0.NumRaw   = (c < 22) ? 8'h10 : 8'hFF;
      @(negedge clock);
      n_checks++;
      if (obs0 !== model_vec(0)) begin
        n_fail++;
        $display("[TB] FAIL snap_model c=%0d: got %h expected %h", c, obs0, model_vec(0));
      end
      exp_num = (c < 18) ? 8'h00 : ((c < 68) ? 8'h10 : 8'hFF);
      n_checks++;
      if (bus0.NumOut !== exp_num) begin
        n_fail++;
        $display("[TB] FAIL snap_num c=%0d: got %h expected %h", c, bus0.NumOut, exp_num);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] num;
    int pulses = 0;
    do_reset();
    bus0.NumRaw = 8'h77; bus0.OpRaw = 2'b11; bus0.EnterRaw = 1'b1;
    repeat (11) @(negedge clock);
    n_checks++;
    if (bus0.Busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_busy: got %b expected 1", bus0.Busy);
    end
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if (obs0 !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL midreset_async: got %h expected %h", obs0, 12'h000);
    end
    @(negedge clock);
    bus0.EnterRaw = 1'b0;
    Reset = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      n_checks++;
      if (obs0 !== model_vec(0)) begin
        n_fail++;
        $display("[TB] FAIL midreset_model c=%0d: got %h expected %h", c, obs0, model_vec(0));
      end
      if (bus0.EnterPulse === 1'b1) pulses++;
    end

    // Second abort: reset lands while the pulse itself is high.
    do_reset();
    num = 8'h80 | 8'($urandom);
    bus0.NumRaw = num; bus0.OpRaw = 2'b01; bus0.EnterRaw = 1'b1;
    repeat (SYNC + DBC) @(negedge clock);
    n_checks++;
    if ({bus0.EnterPulse, bus0.NumOut} !== {1'b1, num}) begin
      n_fail++;
      $display("[TB] FAIL pulsereset_pre: got %b/%h expected 1/%h", bus0.EnterPulse, bus0.NumOut, num);
    end
    #2 Reset = 1'b1;
    bus0.EnterRaw = 1'b0;
    #1;
    n_checks++;
    if (obs0 !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL pulsereset_async: got %h expected %h", obs0, 12'h000);
    end
    @(negedge clock);
    Reset = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      n_checks++;
      if (obs0 !== model_vec(0)) begin
        n_fail++;
        $display("[TB] FAIL pulsereset_model c=%0d: got %h expected %h", c, obs0, model_vec(0));
      end
      if (bus0.EnterPulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_debounce_one();
    logic [7:0] num;
    logic [1:0] op;
    int busy_cycles = 0;
    do_reset();
    num = 8'($urandom); op = 2'($urandom);
    bus1.NumRaw = num; bus1.OpRaw = op;
    for (int c = 1; c <= 10; c++) begin
      bus1.EnterRaw = (c == 1);
      @(negedge clock);
      n_checks++;
      if (obs1 !== model_vec(1)) begin
        n_fail++;
        $display("[TB] FAIL d1_model c=%0d: got %h expected %h", c, obs1, model_vec(1));
      end
      n_checks++;
      if (bus1.EnterPulse !== (c == SYNC + 1)) begin
        n_fail++;
        $display("[TB] FAIL d1_latency c=%0d: got %b expected %b", c, bus1.EnterPulse, (c == SYNC + 1));
      end
      if (bus1.Busy === 1'b1) busy_cycles++;
    end
    n_checks++;
    if (busy_cycles != 1) begin
      n_fail++;
      $display("[TB] FAIL d1_busy: got %0d cycles expected 1", busy_cycles);
    end
    n_checks++;
    if ({bus1.NumOut, bus1.OpOut} !== {num, op}) begin
      n_fail++;
      $display("[TB] FAIL d1_snapshot: got %h/%b expected %h/%b", bus1.NumOut, bus1.OpOut, num, op);
    end
  endtask

  task automatic test_random();
    int left0 = 0;
    int left1 = 0;
    do_reset();
    for (int c = 1; c <= 800; c++) begin
      if (left0 == 0) begin
        bus0.EnterRaw = ~bus0.EnterRaw;
        left0 = $urandom_range(1, 24);
      end
      if (left1 == 0) begin
        bus1.EnterRaw = ~bus1.EnterRaw;
        left1 = $urandom_range(1, 4);
      end
      left0--;
      left1--;
      if ($urandom_range(0, 3) == 0) bus0.NumRaw = 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus0.OpRaw  = 2'($urandom);
      if ($urandom_range(0, 1) == 0) bus1.NumRaw = 8'($urandom);
      if ($urandom_range(0, 1) == 0) bus1.OpRaw  = 2'($urandom);
      @(negedge clock);
      n_checks++;
      if (obs0 !== model_vec(0)) begin
        n_fail++;
        $display("[TB] FAIL random_dut0 c=%0d: got %h expected %h", c, obs0, model_vec(0));
      end
      n_checks++;
      if (obs1 !== model_vec(1)) begin
        n_fail++;
        $display("[TB] FAIL random_dut1 c=%0d: got %h expected %h", c, obs1, model_vec(1));
      end
    end
  endtask

  initial begin
    bus0.EnterRaw = 1'b0; bus0.NumRaw = 8'h00; bus0.OpRaw = 2'b00;
    bus1.EnterRaw = 1'b0; bus1.NumRaw = 8'h00; bus1.OpRaw = 2'b00;
    test_reset();
    test_press();
    test_glitch();
    test_release_bounce();
    test_snapshot();
    test_reset_mid();
    test_debounce_one();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: time %0t reached limit 200000", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
